// File: rtl/confidence_tracker.sv
// Smooths the per-frame face confidence over a sliding window and applies
// hysteresis with a consecutive-update hold to produce a stable detect flag.
module confidence_tracker #(
   parameter int WINDOW      = 4,
   parameter int ON_THRESH   = 20,
   parameter int OFF_THRESH  = 12,
   parameter int HOLD_FRAMES = 3
) (
   input  logic        CLK,
   input  logic        RESET,
   input  logic        done,
   input  logic [0:4]  confidence,
   output logic [0:4]  avg_conf,
   output logic        face_detected,
   output logic        upd,
   output logic [15:0] frame_count
);

   localparam int L  = $clog2(WINDOW);
   localparam int SW = 5 + L;
   localparam logic [4:0] ON_T   = 5'(ON_THRESH);
   localparam logic [4:0] OFF_T  = 5'(OFF_THRESH);
   localparam logic [3:0] HOLD_T = 4'(HOLD_FRAMES);

   typedef enum logic {IDLE, DETECTED} state_e;

   logic                     done_q;
   logic                     accept;
   logic [WINDOW-1:0][4:0]   win_q, win_d;
   logic [SW-1:0]            sum_q, sum_d;
   logic [15:0]              fc_q, fc_d;
   logic                     vld_q, vld_d;
   logic [4:0]               avg_q, avg_d, avg_a;
   logic                     upd_q, upd_d;
   logic [3:0]               streak_q, streak_d, streak_inc;
   state_e                   state_q, state_d;
   logic                     qual;

   always_comb begin
      accept     = done & ~done_q;
      win_d      = win_q;
      sum_d      = sum_q;
      fc_d       = fc_q;
      vld_d      = accept;
      // Stage 1: slot 0 is the newest entry, slot WINDOW-1 the oldest.
      if (accept) begin
         win_d = {win_q[WINDOW-2:0], 5'(confidence)};
         sum_d = sum_q + SW'(confidence) - SW'(win_q[WINDOW-1]);
         fc_d  = fc_q + 16'd1;
      end

      // Stage 2 reads the registered sum, so a new frame entering stage 1 in
      // the same cycle does not disturb the average being published.
      avg_a      = 5'(sum_q >> L);
      streak_inc = streak_q + 4'd1;
      qual       = (state_q == IDLE) ? (avg_a >= ON_T) : (avg_a < OFF_T);
      avg_d      = avg_q;
      upd_d      = vld_q;
      streak_d   = streak_q;
      state_d    = state_q;
      if (vld_q) begin
         avg_d = avg_a;
         if (!qual) begin
            streak_d = 4'd0;
         end else if (streak_inc == HOLD_T) begin
            streak_d = 4'd0;
            state_d  = (state_q == IDLE) ? DETECTED : IDLE;
         end else begin
            streak_d = streak_inc;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         done_q   <= 1'b1;
         win_q    <= '0;
         sum_q    <= '0;
         fc_q     <= '0;
         vld_q    <= 1'b0;
         avg_q    <= '0;
         upd_q    <= 1'b0;
         streak_q <= '0;
         state_q  <= IDLE;
      end else begin
         done_q   <= done;
         win_q    <= win_d;
         sum_q    <= sum_d;
         fc_q     <= fc_d;
         vld_q    <= vld_d;
         avg_q    <= avg_d;
         upd_q    <= upd_d;
         streak_q <= streak_d;
         state_q  <= state_d;
      end
   end

   assign avg_conf      = avg_q;
   assign face_detected = (state_q == DETECTED);
   assign upd           = upd_q;
   assign frame_count   = fc_q;

endmodule

// File: tb/tb_confidence_tracker.sv
// Bench for confidence_tracker: queue-based reference model checked every
// cycle, plus literal expectations for the directed scenarios.
module tb_confidence_tracker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        done = 1'b1;
   logic [0:4]  conf = '0;
   logic [0:4]  avg_conf;
   logic        face_detected, upd;
   logic [15:0] frame_count;

   int n_assert = 0;
   int n_fail   = 0;

   confidence_tracker dut (
      .CLK(clk), .RESET(rst), .done(done), .confidence(conf),
      .avg_conf(avg_conf), .face_detected(face_detected), .upd(upd),
      .frame_count(frame_count)
   );

   always #10 clk = ~clk;

   // Reference model: last four scores as a queue, average by division.
   int m_hist[$];
   int m_det, m_streak, m_fc, m_prev, m_pend, m_pend_avg;
   int e_avg, e_fd, e_upd;
   bit chk_en = 1'b0;

   function automatic void model_reset();
      m_hist = '{0, 0, 0, 0};
      m_det = 0; m_streak = 0; m_fc = 0; m_prev = 1; m_pend = 0;
      e_avg = 0; e_fd = 0; e_upd = 0;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         model_reset();
      end else begin
         e_upd = 0;
         if (m_pend != 0) begin
            int q;
            e_upd = 1;
            e_avg = m_pend_avg;
            q = (m_det != 0) ? (m_pend_avg < 12) : (m_pend_avg >= 20);
            if (q != 0) m_streak++; else m_streak = 0;
            if (m_streak == 3) begin
               m_det = 1 - m_det;
               m_streak = 0;
            end
            e_fd = m_det;
            m_pend = 0;
         end
         if (done && m_prev == 0) begin
            int s;
            m_hist.push_back(int'(conf));
            void'(m_hist.pop_front());
            s = 0;
            foreach (m_hist[i]) s += m_hist[i];
            m_pend_avg = s / 4;
            m_pend = 1;
            m_fc = (m_fc + 1) % 65536;
         end
         m_prev = int'(done);
      end
   end

   task automatic check(input string name, input int act, input int exp);
      n_assert++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   int obs_avg[$];
   int obs_fd[$];

   always @(negedge clk) begin
      if (chk_en) begin
         check("upd", int'(upd), e_upd);
         check("avg_conf", int'(avg_conf), e_avg);
         check("face_detected", int'(face_detected), e_fd);
         check("frame_count", int'(frame_count), m_fc);
      end
      if (upd) begin
         obs_avg.push_back(int'(avg_conf));
         obs_fd.push_back(int'(face_detected));
      end
   end

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse(input int c);
      done = 1'b1;
      conf = 5'(c);
      step();
      done = 1'b0;
      conf = 5'($urandom_range(0, 31));
      step();
   endtask

   task automatic settle();
      step(3);
      obs_avg.delete();
      obs_fd.delete();
   endtask

   task automatic expect_seq(input string name, input int av[], input int fd[]);
      check({name, "_count"}, obs_avg.size(), av.size());
      foreach (av[i]) begin
         if (i < obs_avg.size()) begin
            check({name, "_avg"}, obs_avg[i], av[i]);
            check({name, "_fd"}, obs_fd[i], fd[i]);
         end
      end
   endtask

   initial begin
      model_reset();
      // Reset with done already high; the held level must not count.
      rst = 1'b1; done = 1'b1;
      step(3);
      chk_en = 1'b1;
      rst = 1'b0;
      step(20);
      check("no_upd_after_reset", obs_avg.size(), 0);
      check("fc_after_reset", int'(frame_count), 0);
      check("avg_after_reset", int'(avg_conf), 0);
      done = 1'b0;
      settle();

      // Ramp to detection with a constant score of 24.
      repeat (6) pulse(24);
      step(2);
      expect_seq("ramp", '{6, 12, 18, 24, 24, 24}, '{0, 0, 0, 0, 0, 1});
      check("ramp_fc", int'(frame_count), 6);
      settle();

      // Decay: 16s stay detected, zeros drop it on the third sub-12 average.
      repeat (4) pulse(16);
      repeat (4) pulse(0);
      step(2);
      expect_seq("decay", '{22, 20, 18, 16, 12, 8, 4, 0}, '{1, 1, 1, 1, 1, 1, 1, 0});
      settle();

      // A band average (15) breaks the streak at two; detect needs three more.
      begin
         int sc[10] = '{31, 31, 31, 0, 0, 31, 31, 31, 31, 31};
         foreach (sc[i]) pulse(sc[i]);
      end
      step(2);
      expect_seq("band", '{7, 15, 23, 23, 15, 15, 15, 23, 31, 31},
                 '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1});
      settle();

      // Long done levels count once each.
      begin
         int fc0;
         fc0 = int'(frame_count);
         repeat (3) begin
            done = 1'b1; conf = 5'd9;
            step(10);
            done = 1'b0;
            step();
         end
         step(2);
         check("held_upd_count", obs_avg.size(), 3);
         check("held_fc", int'(frame_count), (fc0 + 3) % 65536);
      end
      settle();

      // Frame counter wrap via a forced preload.
      force dut.fc_q = 16'hFFFF;
      m_fc = 65535;
      step(2);
      release dut.fc_q;
      step();
      check("fc_preload", int'(frame_count), 65535);
      pulse(5);
      step(2);
      check("fc_wrap", int'(frame_count), 0);
      settle();

      // Reset in the cycle after an accepted edge kills the in-flight update.
      done = 1'b1; conf = 5'd31;
      step();
      rst = 1'b1; done = 1'b0;
      step();
      rst = 1'b0;
      step(3);
      check("midreset_no_upd", obs_avg.size(), 0);
      check("midreset_avg", int'(avg_conf), 0);
      check("midreset_fd", int'(face_detected), 0);
      check("midreset_fc", int'(frame_count), 0);

      // Back-to-back after reset still works from a clean window.
      settle();
      pulse(28);
      step(2);
      expect_seq("post_reset", '{7}, '{0});

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
